// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - N/Z/V flag register, branch resolver and saturating overflow counter
// Optional FLAG_BYPASS_EN: same-cycle branches see the flags written by the retiring ALU op.
module alu_flag_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_alu_valid,
  input  logic [2:0]        i_alu_opcode,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_ovfl,
  input  logic              i_stall,
  input  logic              i_br_valid,
  input  logic [2:0]        i_br_ccc,
  output logic              o_br_done,
  output logic              o_br_taken,
  output logic              o_flag_n,
  output logic              o_flag_z,
  output logic              o_flag_v,
  output logic [CNT_W-1:0]  o_ovfl_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_RESOLVE = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_flag_n, r_flag_z, r_flag_v;
  logic [CNT_W-1:0]   r_ovfl_cnt;
  logic [2:0]         r_ccc;
  logic               r_smp_n, r_smp_z, r_smp_v;
  logic               r_br_taken;
  logic               w_upd_nzv, w_upd_z;
  logic               w_n_nxt, w_z_nxt, w_v_nxt;
  logic               w_smp_n, w_smp_z, w_smp_v;
  logic               w_br_accept, w_br_done, w_br_taken, w_eval;

  // ADD/SUB write all three flags; logical/shift ops write Z only; RED/PADDSB write nothing
  always_comb begin
    w_upd_nzv = 1'b0;
    w_upd_z   = 1'b0;
    if (i_alu_valid && !i_stall) begin
      w_upd_nzv = (i_alu_opcode == 3'b000) || (i_alu_opcode == 3'b001);
      w_upd_z   = w_upd_nzv || (i_alu_opcode inside {3'b011, 3'b100, 3'b101, 3'b110});
    end
  end

  assign w_n_nxt = w_upd_nzv ? i_alu_result[DATA_W-1] : r_flag_n;
  assign w_z_nxt = w_upd_z   ? (i_alu_result == '0)   : r_flag_z;
  assign w_v_nxt = w_upd_nzv ? i_alu_ovfl             : r_flag_v;

`ifdef FLAG_BYPASS_EN
  assign w_smp_n = w_n_nxt;
  assign w_smp_z = w_z_nxt;
  assign w_smp_v = w_v_nxt;
`else
  assign w_smp_n = r_flag_n;
  assign w_smp_z = r_flag_z;
  assign w_smp_v = r_flag_v;
`endif

  assign w_br_accept = i_br_valid && !i_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_n   <= 1'b0;
      r_flag_z   <= 1'b0;
      r_flag_v   <= 1'b0;
      r_ovfl_cnt <= '0;
    end else begin
      r_flag_n <= w_n_nxt;
      r_flag_z <= w_z_nxt;
      r_flag_v <= w_v_nxt;
      if (w_upd_nzv && i_alu_ovfl && (r_ovfl_cnt != '1))
        r_ovfl_cnt <= r_ovfl_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ccc      <= 3'b000;
      r_smp_n    <= 1'b0;
      r_smp_z    <= 1'b0;
      r_smp_v    <= 1'b0;
      r_br_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_br_accept) begin
        r_ccc   <= i_br_ccc;
        r_smp_n <= w_smp_n;
        r_smp_z <= w_smp_z;
        r_smp_v <= w_smp_v;
      end
      if (w_br_done)
        r_br_taken <= w_eval;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_br_accept) w_state_nxt = S_RESOLVE;
      S_RESOLVE: if (!i_stall)    w_state_nxt = i_br_valid ? S_RESOLVE : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_eval = 1'b0;
    case (r_ccc)
      3'b000:  w_eval = !r_smp_z;
      3'b001:  w_eval = r_smp_z;
      3'b010:  w_eval = !r_smp_z && !r_smp_n;
      3'b011:  w_eval = r_smp_n;
      3'b100:  w_eval = r_smp_z || !r_smp_n;
      3'b101:  w_eval = r_smp_n || r_smp_z;
      3'b110:  w_eval = r_smp_v;
      default: w_eval = 1'b1;
    endcase
  end

  // Taken is shown live during the done pulse and held from the register afterwards
  always_comb begin
    w_br_done  = (r_state == S_RESOLVE) && !i_stall;
    w_br_taken = w_br_done ? w_eval : r_br_taken;
  end

  assign o_br_done  = w_br_done;
  assign o_br_taken = w_br_taken;
  assign o_flag_n   = r_flag_n;
  assign o_flag_z   = r_flag_z;
  assign o_flag_v   = r_flag_v;
  assign o_ovfl_cnt = r_ovfl_cnt;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - directed vector bench for alu_flag_unit (CNT_W=2)
module tb_alu_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ovfl, stall, br_valid;
  logic [2:0]  alu_opcode, br_ccc;
  logic [15:0] alu_result;
  logic        br_done, br_taken, flag_n, flag_z, flag_v;
  logic [1:0]  ovfl_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FLAG_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  alu_flag_unit #(.DATA_W(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_opcode(alu_opcode), .i_alu_result(alu_result),
    .i_alu_ovfl(alu_ovfl), .i_stall(stall), .i_br_valid(br_valid), .i_br_ccc(br_ccc),
    .o_br_done(br_done), .o_br_taken(br_taken),
    .o_flag_n(flag_n), .o_flag_z(flag_z), .o_flag_v(flag_v), .o_ovfl_cnt(ovfl_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [2:0]  op;
    logic [15:0] res;
    logic        ov;
    logic        st;
    logic        bv;
    logic [2:0]  ccc;
    logic        en, ez, ev, ed, et;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] op, input logic [15:0] res,
                       input logic ov, input logic st, input logic bv, input logic [2:0] ccc);
    alu_valid = av; alu_opcode = op; alu_result = res; alu_ovfl = ov;
    stall = st; br_valid = bv; br_ccc = ccc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          av op    res       ov st bv ccc   N  Z  V  dn tk cnt
    vecs[0]  = '{1, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 2'd0};
    vecs[1]  = '{1, 3'd1, 16'h8000, 1, 0, 0, 3'd0, 0, 1, 0, 0, 0, 2'd0};
    vecs[2]  = '{0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 1, 0, 1, 0, 0, 2'd1};
    vecs[3]  = '{1, 3'd3, 16'h0000, 0, 0, 0, 3'd0, 1, 0, 1, 0, 0, 2'd1};
    vecs[4]  = '{1, 3'd7, 16'h1234, 1, 0, 0, 3'd0, 1, 1, 1, 0, 0, 2'd1};
    vecs[5]  = '{0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 1, 1, 1, 0, 0, 2'd1};
    vecs[6]  = '{1, 3'd2, 16'h0005, 1, 0, 0, 3'd0, 1, 1, 1, 0, 0, 2'd1};
    vecs[7]  = '{1, 3'd4, 16'h0004, 0, 0, 0, 3'd0, 1, 1, 1, 0, 0, 2'd1};
    vecs[8]  = '{1, 3'd0, 16'h8000, 0, 0, 0, 3'd0, 1, 0, 1, 0, 0, 2'd1};
    vecs[9]  = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd0, 1, 0, 0, 0, 0, 2'd1};
    vecs[10] = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd1, 1, 0, 0, 1, 1, 2'd1};
    vecs[11] = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd2, 1, 0, 0, 1, 0, 2'd1};
    vecs[12] = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd3, 1, 0, 0, 1, 0, 2'd1};
    vecs[13] = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd4, 1, 0, 0, 1, 1, 2'd1};
    vecs[14] = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd5, 1, 0, 0, 1, 0, 2'd1};
    vecs[15] = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd6, 1, 0, 0, 1, 1, 2'd1};
    vecs[16] = '{0, 3'd0, 16'h0000, 0, 0, 1, 3'd7, 1, 0, 0, 1, 0, 2'd1};
    vecs[17] = '{0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 1, 0, 0, 1, 1, 2'd1};
    vecs[18] = '{0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 2'd1};
    vecs[19] = '{1, 3'd0, 16'h7fff, 1, 0, 0, 3'd0, 1, 0, 0, 0, 1, 2'd1};
    vecs[20] = '{1, 3'd0, 16'h7fff, 1, 0, 0, 3'd0, 0, 0, 1, 0, 1, 2'd2};
    vecs[21] = '{1, 3'd1, 16'h0001, 1, 0, 0, 3'd0, 0, 0, 1, 0, 1, 2'd3};
    vecs[22] = '{1, 3'd0, 16'h0000, 1, 0, 0, 3'd0, 0, 0, 1, 0, 1, 2'd3};
    vecs[23] = '{0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 0, 1, 1, 0, 1, 2'd3};
    vecs[24] = '{1, 3'd0, 16'h8000, 0, 1, 0, 3'd0, 0, 1, 1, 0, 1, 2'd3};
    vecs[25] = '{0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 0, 1, 1, 0, 1, 2'd3};

    // Reset state, then reset asserted while a branch is resolving
    rst_n = 1'b0;
    drive(0, 3'd0, 16'h0, 0, 0, 0, 3'd0);
    #2;
    chk("rst_flag_n", flag_n, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_v", flag_v, 0);
    chk("rst_br_done", br_done, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_ovfl_cnt", ovfl_cnt, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 3'd0, 16'h0, 0, 0, 1, 3'd7);
    #2;
    chk("idle_no_done", br_done, 0);
    tick();
    drive(0, 3'd0, 16'h0, 0, 0, 0, 3'd0);
    #1;
    chk("resolve_done", br_done, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", br_done, 0);
    chk("midrst_taken", br_taken, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("postrst_done%0d", i), br_done, 0);
      tick();
    end

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].av, vecs[i].op, vecs[i].res, vecs[i].ov, vecs[i].st, vecs[i].bv, vecs[i].ccc);
      #2;
      chk($sformatf("v%0d_flag_n", i), flag_n, vecs[i].en);
      chk($sformatf("v%0d_flag_z", i), flag_z, vecs[i].ez);
      chk($sformatf("v%0d_flag_v", i), flag_v, vecs[i].ev);
      chk($sformatf("v%0d_br_done", i), br_done, vecs[i].ed);
      chk($sformatf("v%0d_br_taken", i), br_taken, vecs[i].et);
      chk($sformatf("v%0d_ovfl_cnt", i), ovfl_cnt, vecs[i].cnt);
      tick();
    end

    // Same-cycle ALU op and branch, then a stalled resolution
    drive(1, 3'd0, 16'h0001, 0, 0, 0, 3'd0);
    tick();
    drive(1, 3'd0, 16'h0000, 0, 0, 1, 3'd1);
    #2;
    chk("same_pre_z", flag_z, 0);
    chk("same_pre_done", br_done, 0);
    tick();
    drive(0, 3'd0, 16'h0, 0, 0, 1, 3'd0);
    #2;
    chk("same_done", br_done, 1);
    chk("same_taken", br_taken, BYP);
    chk("same_z", flag_z, 1);
    tick();
    drive(0, 3'd0, 16'h0, 0, 1, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("stall%0d_done", i), br_done, 0);
      chk($sformatf("stall%0d_taken", i), br_taken, BYP);
      tick();
    end
    drive(0, 3'd0, 16'h0, 0, 0, 0, 3'd0);
    #2;
    chk("unstall_done", br_done, 1);
    chk("unstall_taken", br_taken, 0);
    tick();
    #2;
    chk("after_done", br_done, 0);
    chk("after_taken", br_taken, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
